// File: rtl/firc_pkg.sv
// Shared widths and types for the complex FIR filter front end (firc_driver).
package firc_pkg;

  localparam int SAMP_W = 24;
  localparam int COEF_W = 27;
  localparam int NCOEF  = 15;
  localparam int ADDR_W = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_GAP,
    S_STREAM
  } drv_state_t;

  typedef struct packed {
    logic signed [SAMP_W-1:0] I;
    logic signed [SAMP_W-1:0] Q;
  } samp_t;

  typedef struct packed {
    logic signed [COEF_W-1:0] I;
    logic signed [COEF_W-1:0] Q;
  } coef_t;

endpackage

// File: rtl/firc_drv_fifo.sv
// Synchronous I/Q sample FIFO with occupancy count; storage is cleared by reset.
// The caller must not assert wr_en when full or rd_en when empty.
module firc_drv_fifo
  import firc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     wr_en,
  input  samp_t                    wr_data,
  input  logic                     rd_en,
  output samp_t                    rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  samp_t              mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/firc_driver.sv
// Front end for firc: replays the host coefficient table on Start, then streams FIFO samples.
// Define FIRC_DRV_STATS_EN to build the SampCount transfer counter.
module firc_driver
  import firc_pkg::*;
#(
  parameter int NCOEF      = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     CfgWr,
  input  logic [ADDR_W-1:0]        CfgAddr,
  input  logic signed [COEF_W-1:0] CfgI,
  input  logic signed [COEF_W-1:0] CfgQ,
  input  logic                     Start,
  output logic                     Busy,
  input  logic                     SrcValid,
  output logic                     SrcReady,
  input  logic signed [SAMP_W-1:0] SrcI,
  input  logic signed [SAMP_W-1:0] SrcQ,
  output logic                     PushCoef,
  output logic [ADDR_W-1:0]        CoefAddr,
  output logic signed [COEF_W-1:0] CoefI,
  output logic signed [COEF_W-1:0] CoefQ,
  output logic                     PushIn,
  input  logic                     StopIn,
  output logic signed [SAMP_W-1:0] SampI,
  output logic signed [SAMP_W-1:0] SampQ,
  output logic [31:0]              SampCount
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  drv_state_t          state, state_d;
  logic [ADDR_W-1:0]   load_idx, idx_d;
  coef_t               tbl [1:NCOEF];
  coef_t               coef_sel;
  logic                push_coef_d;
  logic                busy_d;
  logic                accept;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  samp_t               fifo_head;

  // Host table writes are dropped while a replay is in progress.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int k = 1; k <= NCOEF; k++) tbl[k] <= '0;
    end else if (CfgWr && !Busy) begin
      for (int k = 1; k <= NCOEF; k++)
        if (CfgAddr == ADDR_W'(k)) tbl[k] <= '{I: CfgI, Q: CfgQ};
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      load_idx <= '0;
    end else begin
      state    <= state_d;
      load_idx <= idx_d;
    end
  end

  always_comb begin
    state_d = state;
    idx_d   = load_idx;
    case (state)
      S_IDLE, S_STREAM: begin
        if (Start) begin
          state_d = S_LOAD;
          idx_d   = ADDR_W'(1);
        end
      end
      S_LOAD: begin
        if (load_idx == ADDR_W'(NCOEF)) state_d = S_GAP;
        else                             idx_d   = load_idx + 1'b1;
      end
      S_GAP:   state_d = S_STREAM;
      default: state_d = S_IDLE;
    endcase
  end

  // Coefficient outputs are registered from the next state so PushCoef lines up with LOAD.
  always_comb begin
    push_coef_d = (state_d == S_LOAD);
    busy_d      = (state_d == S_LOAD) || (state_d == S_GAP);
    coef_sel    = '0;
    for (int k = 1; k <= NCOEF; k++)
      if (idx_d == ADDR_W'(k)) coef_sel = tbl[k];
    PushIn = (state == S_STREAM) && !fifo_empty && !StopIn;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      PushCoef <= 1'b0;
      Busy     <= 1'b0;
      CoefAddr <= '0;
      CoefI    <= '0;
      CoefQ    <= '0;
    end else begin
      PushCoef <= push_coef_d;
      Busy     <= busy_d;
      if (push_coef_d) begin
        CoefAddr <= idx_d;
        CoefI    <= coef_sel.I;
        CoefQ    <= coef_sel.Q;
      end
    end
  end

  assign SrcReady   = (fifo_count < CNT_W'(FIFO_DEPTH)) && !Reset;
  assign accept     = SrcValid && SrcReady;
  assign fifo_empty = (fifo_count == '0);

  firc_drv_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk     (Clk),
    .Reset   (Reset),
    .wr_en   (accept),
    .wr_data ('{I: SrcI, Q: SrcQ}),
    .rd_en   (PushIn),
    .rd_data (fifo_head),
    .count   (fifo_count)
  );

  assign SampI = fifo_head.I;
  assign SampQ = fifo_head.Q;

`ifdef FIRC_DRV_STATS_EN
  logic start_ok;
  assign start_ok = Start && ((state == S_IDLE) || (state == S_STREAM));

  // A replay restart takes priority over a transfer in the same cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)         SampCount <= '0;
    else if (start_ok) SampCount <= '0;
    else if (PushIn)   SampCount <= SampCount + 32'd1;
  end
`else
  assign SampCount = '0;
`endif

endmodule

// File: tb/tb_firc_driver.sv
// Directed self-checking bench for firc_driver: replay, backpressure, prefill, illegal writes, reset.
module tb_firc_driver;
  import firc_pkg::*;

  logic                     Clk = 1'b0;
  logic                     Reset;
  logic                     CfgWr;
  logic [ADDR_W-1:0]        CfgAddr;
  logic signed [COEF_W-1:0] CfgI, CfgQ;
  logic                     Start;
  logic                     Busy;
  logic                     SrcValid;
  logic                     SrcReady;
  logic signed [SAMP_W-1:0] SrcI, SrcQ;
  logic                     PushCoef;
  logic [ADDR_W-1:0]        CoefAddr;
  logic signed [COEF_W-1:0] CoefI, CoefQ;
  logic                     PushIn;
  logic                     StopIn;
  logic signed [SAMP_W-1:0] SampI, SampQ;
  logic [31:0]              SampCount;

  int checks = 0;
  int errors = 0;

`ifdef FIRC_DRV_STATS_EN
  localparam int EXP_COUNT = 10;
`else
  localparam int EXP_COUNT = 0;
`endif

  firc_driver #(.NCOEF(15), .FIFO_DEPTH(4)) dut (
    .Clk(Clk), .Reset(Reset), .CfgWr(CfgWr), .CfgAddr(CfgAddr), .CfgI(CfgI), .CfgQ(CfgQ),
    .Start(Start), .Busy(Busy), .SrcValid(SrcValid), .SrcReady(SrcReady), .SrcI(SrcI),
    .SrcQ(SrcQ), .PushCoef(PushCoef), .CoefAddr(CoefAddr), .CoefI(CoefI), .CoefQ(CoefQ),
    .PushIn(PushIn), .StopIn(StopIn), .SampI(SampI), .SampQ(SampQ), .SampCount(SampCount)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // One host config write, applied before the next rising edge.
  task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input int ci, input int cq);
    CfgWr   = 1'b1;
    CfgAddr = addr;
    CfgI    = COEF_W'(ci);
    CfgQ    = COEF_W'(cq);
    @(negedge Clk);
    CfgWr = 1'b0;
  endtask

  // Pulses Start, then checks cycles 1..15 of LOAD, the GAP cycle and cycle 17.
  // During LOAD it also prefills samples, attempts a table write and a second Start.
  // resetAt > 0 asserts Reset in that LOAD cycle instead.
  task automatic runReplay(input bit zeroTab, input int nPrefill, input int resetAt);
    int busyCycles = 0;
    Start = 1'b1;
    @(negedge Clk);
    for (int k = 1; k <= NCOEF; k++) begin
      SrcValid = (k <= nPrefill);
      SrcI     = SAMP_W'(10 + k);
      SrcQ     = SAMP_W'(-(10 + k));
      CfgWr    = (k == 3);
      CfgAddr  = 5'd5;
      CfgI     = 27'sd777;
      CfgQ     = 27'sd777;
      Start    = (k == 8);
      if (k == resetAt) begin
        Reset = 1'b1;
        #1;
        checkOutput("rstPushCoef", PushCoef, 0);
        checkOutput("rstCoefAddr", CoefAddr, 0);
        checkOutput("rstCoefI", CoefI, 0);
        checkOutput("rstCoefQ", CoefQ, 0);
        checkOutput("rstBusy", Busy, 0);
        checkOutput("rstPushIn", PushIn, 0);
        checkOutput("rstSampI", SampI, 0);
        checkOutput("rstSrcReady", SrcReady, 0);
        checkOutput("rstSampCount", SampCount, 0);
        @(negedge Clk);
        Reset = 1'b0; Start = 1'b0; CfgWr = 1'b0; SrcValid = 1'b0;
        #1;
        checkOutput("postRstSrcReady", SrcReady, 1);
        return;
      end
      #1;
      if (Busy) busyCycles++;
      checkOutput("pushCoef", PushCoef, 1);
      checkOutput("coefAddr", CoefAddr, k);
      checkOutput("coefI", CoefI, zeroTab ? 0 : k);
      checkOutput("coefQ", CoefQ, zeroTab ? 0 : -k);
      if (k == 1) checkOutput("sampCountCleared", SampCount, 0);
      if (nPrefill == 4 && k == 5) checkOutput("srcReadyFull", SrcReady, 0);
      @(negedge Clk);
    end
    SrcValid = 1'b0; CfgWr = 1'b0; Start = 1'b0;
    #1;
    if (Busy) busyCycles++;
    checkOutput("gapPushCoef", PushCoef, 0);
    checkOutput("gapPushIn", PushIn, 0);
    checkOutput("gapCoefAddrHold", CoefAddr, NCOEF);
    @(negedge Clk);
    #1;
    if (Busy) busyCycles++;
    checkOutput("busyCycles", busyCycles, 16);
    checkOutput("firstPushIn", PushIn, (nPrefill > 0) ? 1 : 0);
    if (nPrefill > 0) begin
      checkOutput("firstSampI", SampI, 11);
      checkOutput("firstSampQ", SampQ, -11);
    end
  endtask

  initial begin
    bit expPush [1:11];
    int nxt;
    int expOut;
    expPush = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0};
    Reset = 1'b1; CfgWr = 1'b0; CfgAddr = '0; CfgI = '0; CfgQ = '0; Start = 1'b0;
    SrcValid = 1'b0; SrcI = '0; SrcQ = '0; StopIn = 1'b0;
    @(negedge Clk);
    #1;
    checkOutput("resetSrcReady", SrcReady, 0);
    checkOutput("resetBusy", Busy, 0);
    checkOutput("resetPushCoef", PushCoef, 0);
    checkOutput("resetPushIn", PushIn, 0);
    checkOutput("resetSampCount", SampCount, 0);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    checkOutput("readyAfterReset", SrcReady, 1);

    for (int k = 1; k <= NCOEF; k++) applyStimulus(ADDR_W'(k), k, -k);
    applyStimulus(5'd0, 999, 999);
    applyStimulus(5'd20, 999, 999);

    $display("[TB] replay with prefill");
    runReplay(1'b0, 4, 0);
    for (int n = 12; n <= 14; n++) begin
      @(negedge Clk);
      #1;
      if (n == 12) checkOutput("readyAfterPop", SrcReady, 1);
      checkOutput("drainPushIn", PushIn, 1);
      checkOutput("drainSampI", SampI, n);
    end
    @(negedge Clk);
    #1;
    checkOutput("drainEmpty", PushIn, 0);

    $display("[TB] backpressure");
    nxt = 1;
    expOut = 1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge Clk);
      SrcValid = (nxt <= 6);
      SrcI     = SAMP_W'(nxt);
      SrcQ     = SAMP_W'(-nxt);
      StopIn   = (c >= 2 && c <= 4);
      #1;
      checkOutput($sformatf("bpPushIn%0d", c), PushIn, expPush[c]);
      if (expPush[c]) begin
        checkOutput($sformatf("bpSampI%0d", c), SampI, expOut);
        expOut++;
      end
      if (c == 4) checkOutput("bpReady3", SrcReady, 1);
      if (c == 5) checkOutput("bpReadyFull", SrcReady, 0);
      if (SrcValid && SrcReady) nxt++;
    end
    SrcValid = 1'b0; StopIn = 1'b0;
    checkOutput("bpAllAccepted", nxt, 7);
    checkOutput("sampCount", SampCount, EXP_COUNT);

    $display("[TB] replay after illegal writes");
    runReplay(1'b0, 0, 0);

    $display("[TB] mid-load reset");
    runReplay(1'b0, 2, 7);
    @(negedge Clk);
    runReplay(1'b1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
